// File: rtl/cache_prof_pkg.sv
// Shared definitions for the cache profiling models: FSM encoding, clog2 and
// the saturating counter increment used by every statistics counter.
package cache_prof_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2
  } prof_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Counters stick at their all-ones value instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// True-LRU age vector update for one set: promotes the hit way (or the victim
// on a miss) to age 0 and shifts the ages it overtakes by one.
module lru_age_update
  import cache_prof_pkg::*;
#(
  parameter int WAYS  = 16,
  parameter int WAY_W = clog2(WAYS)
) (
  input  logic [WAYS-1:0][WAY_W-1:0] ages_in,
  input  logic                       hit,
  input  logic [WAY_W-1:0]           hit_way,
  output logic [WAYS-1:0][WAY_W-1:0] ages_out,
  output logic [WAY_W-1:0]           victim
);

  logic [WAY_W-1:0] hit_age;

  // Invalid ways always carry the oldest ages, so the oldest way doubles as
  // the next free slot while the set is still filling.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_in[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
  end

  always_comb begin
    ages_out = ages_in;
    hit_age  = ages_in[hit_way];
    for (int w = 0; w < WAYS; w++) begin
      if (hit) begin
        if (WAY_W'(w) == hit_way)      ages_out[w] = '0;
        else if (ages_in[w] < hit_age) ages_out[w] = ages_in[w] + WAY_W'(1);
      end else begin
        if (WAY_W'(w) == victim) ages_out[w] = '0;
        else                     ages_out[w] = ages_in[w] + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/lru_stack_profiler.sv
// Trace-driven set-associative true-LRU cache model that bins every hit by its
// LRU stack depth into nested saturating counters.
module lru_stack_profiler
  import cache_prof_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WAYS        = 16,
  parameter int SETS        = 64,
  parameter int BLOCK_BYTES = 16,
  parameter int MIN_DEPTH   = 4,
  parameter int CNT_W       = 20
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            trace_valid,
  output logic                                            trace_ready,
  input  logic [ADDR_W-1:0]                               mem_addr,
  input  logic                                            flush,
  input  logic                                            clr_stats,
  output logic                                            res_valid,
  output logic                                            res_hit,
  output logic [clog2(WAYS)-1:0]                          res_depth,
  output logic [CNT_W-1:0]                                access_count,
  output logic [CNT_W-1:0]                                miss_count,
  output logic [(clog2(WAYS/MIN_DEPTH)+1)*CNT_W-1:0]      bin_count
);

  localparam int OFF_W = clog2(BLOCK_BYTES);
  localparam int IDX_W = clog2(SETS);
  localparam int WAY_W = clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int NBINS = clog2(WAYS / MIN_DEPTH) + 1;

  prof_state_e state_q, state_d;
  logic accept, do_flush, do_update;

  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic             hit_q;
  logic [WAY_W-1:0] hit_way_q, hit_age_q;

  logic [SETS-1:0][WAYS-1:0]   valid_q;
  logic [TAG_W-1:0]            tag_mem [SETS][WAYS];
  logic [WAYS-1:0][WAY_W-1:0]  age_q   [SETS];
  logic [CNT_W-1:0]            bins_q  [NBINS];

  logic                        lk_hit;
  logic [WAY_W-1:0]            lk_way;
  logic [WAYS-1:0][WAY_W-1:0]  ages_nxt;
  logic [WAY_W-1:0]            victim_way;
  logic                        unused_offset;

  assign unused_offset = ^mem_addr[OFF_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (trace_valid && !flush) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trace_ready = (state_q == ST_IDLE) && !flush;
    accept      = trace_ready && trace_valid;
    do_flush    = (state_q == ST_IDLE) && flush;
    do_update   = (state_q == ST_UPDATE);
  end

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_q][w] && tag_mem[idx_q][w] == tag_q) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  lru_age_update #(.WAYS(WAYS), .WAY_W(WAY_W)) u_age (
    .ages_in  (age_q[idx_q]),
    .hit      (hit_q),
    .hit_way  (hit_way_q),
    .ages_out (ages_nxt),
    .victim   (victim_way)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      tag_q        <= '0;
      hit_q        <= 1'b0;
      hit_way_q    <= '0;
      hit_age_q    <= '0;
      valid_q      <= '0;
      res_valid    <= 1'b0;
      res_hit      <= 1'b0;
      res_depth    <= '0;
      access_count <= '0;
      miss_count   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w] <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
      for (int k = 0; k < NBINS; k++) bins_q[k] <= '0;
    end else begin
      res_valid <= 1'b0;
      if (accept) begin
        idx_q <= mem_addr[OFF_W +: IDX_W];
        tag_q <= mem_addr[ADDR_W-1 -: TAG_W];
      end
      if (state_q == ST_LOOKUP) begin
        hit_q     <= lk_hit;
        hit_way_q <= lk_way;
        hit_age_q <= lk_hit ? age_q[idx_q][lk_way] : '0;
      end
      if (do_flush) begin
        valid_q <= '0;
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
      if (do_update) begin
        age_q[idx_q] <= ages_nxt;
        if (!hit_q) begin
          valid_q[idx_q][victim_way] <= 1'b1;
          tag_mem[idx_q][victim_way] <= tag_q;
        end
        res_valid <= 1'b1;
        res_hit   <= hit_q;
        res_depth <= hit_age_q;
      end
      // A clear coincident with an update wins; that access goes uncounted.
      if (clr_stats) begin
        access_count <= '0;
        miss_count   <= '0;
        for (int k = 0; k < NBINS; k++) bins_q[k] <= '0;
      end else if (do_update) begin
        access_count <= CNT_W'(sat_inc(64'(access_count), CNT_W));
        if (!hit_q) miss_count <= CNT_W'(sat_inc(64'(miss_count), CNT_W));
        for (int k = 0; k < NBINS; k++) begin
          if (hit_q && (32'(hit_age_q) < (MIN_DEPTH << k)))
            bins_q[k] <= CNT_W'(sat_inc(64'(bins_q[k]), CNT_W));
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NBINS; k++) bin_count[k*CNT_W +: CNT_W] = bins_q[k];
  end

endmodule

// File: tb/tb_lru_stack_profiler.sv
// Bench for lru_stack_profiler: MRU-ordered tag lists per set as reference,
// per-cycle comparison, directed scenarios plus a randomized trace.
module tb_lru_stack_profiler;

  localparam int ADDR_W = 32;
  localparam int WAYS   = 16;
  localparam int SETS   = 64;
  localparam int MIN_D  = 4;
  localparam int CNT_W  = 20;
  localparam int WAY_W  = 4;
  localparam int NBINS  = 3;
  localparam int CNT2_W = 4;

  logic clk;
  logic rst_n, tv, fl, cs;
  logic [ADDR_W-1:0] ma;
  logic trace_ready, res_valid, res_hit;
  logic [WAY_W-1:0] res_depth;
  logic [CNT_W-1:0] access_count, miss_count;
  logic [NBINS*CNT_W-1:0] bin_count;

  logic rst2, tv2;
  logic [ADDR_W-1:0] ma2;
  logic ready2, rv2, rh2;
  logic [WAY_W-1:0] rd2;
  logic [CNT2_W-1:0] acc2, miss2;
  logic [NBINS*CNT2_W-1:0] bins2;

  lru_stack_profiler dut (
    .clk(clk), .reset(rst_n), .trace_valid(tv), .trace_ready(trace_ready),
    .mem_addr(ma), .flush(fl), .clr_stats(cs), .res_valid(res_valid),
    .res_hit(res_hit), .res_depth(res_depth), .access_count(access_count),
    .miss_count(miss_count), .bin_count(bin_count)
  );

  lru_stack_profiler #(.CNT_W(CNT2_W)) dut2 (
    .clk(clk), .reset(rst2), .trace_valid(tv2), .trace_ready(ready2),
    .mem_addr(ma2), .flush(1'b0), .clr_stats(1'b0), .res_valid(rv2),
    .res_hit(rh2), .res_depth(rd2), .access_count(acc2),
    .miss_count(miss2), .bin_count(bins2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: per set, the resident tags from most to least recently used.
  int unsigned stk [SETS][$];
  int     countdown = 0;
  bit     exp_pulse = 0, exp_hit = 0, p_hit = 0;
  int     exp_depth = 0, p_depth = 0;
  longint m_acc = 0, m_miss = 0;
  longint m_bin [NBINS];
  longint cmax = (64'd1 << CNT_W) - 1;

  function automatic void model_access(input logic [ADDR_W-1:0] a);
    int unsigned s, t;
    int pos;
    s = (a >> 4) & 63;
    t = a >> 10;
    pos = -1;
    for (int i = 0; i < stk[s].size(); i++) if (stk[s][i] == t) pos = i;
    if (pos >= 0) begin
      p_hit = 1; p_depth = pos;
      stk[s].delete(pos);
    end else begin
      p_hit = 0; p_depth = 0;
      if (stk[s].size() == WAYS) void'(stk[s].pop_back());
    end
    stk[s].push_front(t);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit was_idle;
    if (!rst_n) begin
      countdown = 0; exp_pulse = 0; m_acc = 0; m_miss = 0;
      for (int k = 0; k < NBINS; k++) m_bin[k] = 0;
      for (int s = 0; s < SETS; s++) stk[s].delete();
    end else begin
      was_idle = (countdown == 0);
      exp_pulse = 0;
      if (!was_idle) begin
        countdown--;
        if (countdown == 0) begin
          exp_pulse = 1; exp_hit = p_hit; exp_depth = p_depth;
          if (!cs) begin
            if (m_acc < cmax) m_acc++;
            if (!p_hit && m_miss < cmax) m_miss++;
            for (int k = 0; k < NBINS; k++)
              if (p_hit && p_depth < (MIN_D << k) && m_bin[k] < cmax) m_bin[k]++;
          end
        end
      end
      if (cs) begin
        m_acc = 0; m_miss = 0;
        for (int k = 0; k < NBINS; k++) m_bin[k] = 0;
      end
      if (was_idle && fl) begin
        for (int s = 0; s < SETS; s++) stk[s].delete();
      end else if (was_idle && tv) begin
        model_access(ma);
        countdown = 2;
      end
    end
  end

  function automatic bit all_perm();
    bit ok;
    bit [WAYS-1:0] seen;
    ok = 1;
    for (int s = 0; s < SETS; s++) begin
      seen = '0;
      for (int w = 0; w < WAYS; w++) seen[dut.age_q[s][w]] = 1'b1;
      if (seen != {WAYS{1'b1}}) ok = 0;
    end
    return ok;
  endfunction

  bit last_hit;
  int last_depth;

  always @(negedge clk) begin
    chk("res_valid", res_valid, exp_pulse);
    chk("trace_ready", trace_ready, (countdown == 0 && !fl));
    if (exp_pulse) begin
      chk("res_hit", res_hit, exp_hit);
      chk("res_depth", res_depth, exp_depth);
      chk("age_perm", all_perm(), 1);
    end
    if (res_valid) begin
      last_hit = res_hit; last_depth = int'(res_depth);
    end
    chk("access_count", access_count, m_acc);
    chk("miss_count", miss_count, m_miss);
    for (int k = 0; k < NBINS; k++) chk($sformatf("bin%0d", k), bin_count[k*CNT_W +: CNT_W], m_bin[k]);
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic acc(input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    while (countdown != 0 && n < 10) begin step(); n++; end
    if (countdown != 0) begin
      errors++;
      $display("FAIL acc_wait actual=busy required=idle at %0t", $time);
    end
    tv = 1; ma = a;
    step();
    tv = 0;
  endtask

  task automatic settle();
    repeat (4) step();
  endtask

  task automatic do_reset();
    rst_n = 0; step(); step(); rst_n = 1; step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; tv = 0; fl = 0; cs = 0; ma = '0;
    rst2 = 0; tv2 = 0; ma2 = '0;
    step(); step();
    chk("reset_ready", trace_ready, 1);
    chk("reset_acc", access_count, 0);
    rst_n = 1; rst2 = 1; step();

    // two accesses to 0x0: miss then hit at depth 0
    acc(32'h0); acc(32'h0); settle();
    chk("t1_hit", last_hit, 1);
    chk("t1_depth", last_depth, 0);
    chk("t1_acc", access_count, 2);
    chk("t1_miss", miss_count, 1);
    for (int k = 0; k < NBINS; k++) chk("t1_bin", bin_count[k*CNT_W +: CNT_W], 1);

    // fill set 0 with 16 tags, then the oldest-touched is depth 15
    do_reset();
    for (int k = 0; k < 16; k++) acc(32'(k) << 10);
    acc(32'h0); settle();
    chk("t2_hit", last_hit, 1);
    chk("t2_depth", last_depth, 15);
    chk("t2_bin0", bin_count[0 +: CNT_W], 0);
    chk("t2_bin1", bin_count[CNT_W +: CNT_W], 0);
    chk("t2_bin2", bin_count[2*CNT_W +: CNT_W], 1);
    acc(32'(16) << 10); acc(32'(1) << 10); settle();
    chk("t2_evict_hit", last_hit, 0);
    chk("t2_evict_miss", miss_count, 18);

    // six tags, re-access the first at depth 5
    do_reset();
    for (int k = 0; k < 6; k++) acc(32'(k + 3) << 10);
    acc(32'(3) << 10); settle();
    chk("t3_depth", last_depth, 5);
    chk("t3_bin0", bin_count[0 +: CNT_W], 0);
    chk("t3_bin1", bin_count[CNT_W +: CNT_W], 1);
    chk("t3_bin2", bin_count[2*CNT_W +: CNT_W], 1);

    // flush the cycle after accept: in-flight access still completes
    do_reset();
    acc(32'h0);
    acc(32'h400);
    fl = 1; repeat (4) step(); fl = 0;
    acc(32'h0); settle();
    chk("t5_hit", last_hit, 0);
    chk("t5_acc", access_count, 3);
    chk("t5_miss", miss_count, 3);

    // clear coincident with update wins
    acc(32'h10);
    step(); cs = 1; step(); cs = 0; settle();
    chk("clr_acc", access_count, 0);
    chk("clr_miss", miss_count, 0);

    // reset during LOOKUP
    acc(32'h20);
    rst_n = 0; step(); rst_n = 1; settle();
    chk("t6_ready", trace_ready, 1);
    chk("t6_acc", access_count, 0);

    // saturation on a CNT_W=4 instance: 1 miss + 20 hits
    tv2 = 1; ma2 = 32'h40;
    repeat (63) step();
    tv2 = 0; settle();
    chk("t4_acc", acc2, 15);
    chk("t4_miss", miss2, 1);
    for (int k = 0; k < NBINS; k++) chk("t4_bin", bins2[k*CNT2_W +: CNT2_W], 15);

    // randomized trace on a small working set to get a spread of depths
    for (int i = 0; i < 4000; i++) begin
      step();
      tv = 1'($urandom_range(0, 1));
      ma = (32'($urandom_range(0, 23)) << 10) | (32'($urandom_range(0, 3)) << 4)
         | 32'($urandom_range(0, 15));
      fl = ($urandom_range(0, 79) == 0);
      cs = ($urandom_range(0, 149) == 0);
      if (i == 2000) begin rst_n = 0; step(); rst_n = 1; end
    end
    tv = 0; fl = 0; cs = 0;
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
